mat_seq_master: RTL and testbench

MAT_SEQ_MASTER -- requirements
Module: mat_seq_master

---
 rtl/mat_bus_pkg.sv | 55 +++++
 rtl/mat_feed_addr_gen.sv | 32 +++
 rtl/mat_seq_master.sv | 206 ++++++++++++++++++++
 tb/tb_mat_seq_master.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_bus_pkg.sv
// Shared definitions for the matrix-sequencer bus master: register map,
// default operand bases, FSM state encoding and the bus command payload.
package mat_bus_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FEED_CNT_W = 4;

    // Default operand locations in memory
    localparam logic [ADDR_W-1:0] DEF_A_BASE = 8'h20;
    localparam logic [ADDR_W-1:0] DEF_B_BASE = 8'h40;

    // Accelerator register map
    localparam logic [ADDR_W-1:0] REG_A_FEED = 8'h00;
    localparam logic [ADDR_W-1:0] REG_B_FEED = 8'h01;
    localparam logic [ADDR_W-1:0] REG_INT_EN = 8'h02;
    localparam logic [ADDR_W-1:0] REG_MUL_GO = 8'h03;
    localparam logic [ADDR_W-1:0] REG_ADD_GO = 8'h04;
    localparam logic [ADDR_W-1:0] REG_CLR    = 8'h05;
    localparam logic [ADDR_W-1:0] REG_RESULT = 8'h06;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FEED_RD  = 4'd1,
        FEED_WR  = 4'd2,
        MUL_GO   = 4'd3,
        MUL_WAIT = 4'd4,
        INT_EN   = 4'd5,
        ADD_GO   = 4'd6,
        ADD_WAIT = 4'd7,
        RF_RD    = 4'd8,
        CLR      = 4'd9,
        DONE     = 4'd10,
        ERR      = 4'd11
    } state_t;

    typedef struct packed {
        logic              req;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_cmd_t;

    // Build a requesting write command
    function automatic bus_cmd_t bus_write(input logic [ADDR_W-1:0] a,
                                           input logic [DATA_W-1:0] d);
        bus_cmd_t c;
        c.req  = 1'b1;
        c.wr   = 1'b1;
        c.addr = a;
        c.data = d;
        return c;
    endfunction

endpackage

// File: rtl/mat_feed_addr_gen.sv
// Maps the 4-bit feed-pair counter to the operand read address and the
// feed register it is written to.
//   cnt       : feed pair index 0..15
//   rd_addr_c : memory address to read (A for pairs 0-7, B for pairs 8-15)
//   wr_addr_c : feed register target (A feed or B feed)
module mat_feed_addr_gen
    import mat_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] A_BASE = DEF_A_BASE,
    parameter logic [ADDR_W-1:0] B_BASE = DEF_B_BASE
) (
    input  logic [FEED_CNT_W-1:0] cnt,
    output logic [ADDR_W-1:0]     rd_addr_c,
    output logic [ADDR_W-1:0]     wr_addr_c
);

    logic [1:0] offset;

    // A is walked 0,1,0,1,2,3,2,3 (rows repeated); B is walked 0..3 twice
    always_comb begin
        if (cnt[FEED_CNT_W-1]) begin
            offset    = cnt[1:0];
            rd_addr_c = B_BASE + ADDR_W'(offset);
            wr_addr_c = REG_B_FEED;
        end else begin
            offset    = {cnt[2], cnt[0]};
            rd_addr_c = A_BASE + ADDR_W'(offset);
            wr_addr_c = REG_A_FEED;
        end
    end

endmodule

// File: rtl/mat_seq_master.sv
// Bus master that sequences one 2x2 matrix multiply job on the accelerator:
// feeds A and B from memory, kicks the multiplier, enables the interrupt,
// kicks the adder, reads the result register and clears the accelerator.
//   clk, reset           : clock, async active-high reset
//   start                : one-cycle job request (accepted in IDLE/DONE/ERR)
//   M_req/M_grant        : arbiter handshake; a bus step completes on grant
//   M_wr/M_address/M_dout: bus command (registered)
//   M_din                : read data, valid the cycle after a granted read
//   multi_opdone         : multiplier finished level
//   m_interrupt          : adder/write-back finished level
//   busy/done/err        : job status (done is a pulse, err is sticky)
module mat_seq_master
    import mat_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] A_BASE = DEF_A_BASE,
    parameter logic [ADDR_W-1:0] B_BASE = DEF_B_BASE,
    parameter int unsigned       TMO_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              M_req,
    input  logic              M_grant,
    output logic              M_wr,
    output logic [ADDR_W-1:0] M_address,
    output logic [DATA_W-1:0] M_dout,
    input  logic [DATA_W-1:0] M_din,
    input  logic              multi_opdone,
    input  logic              m_interrupt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Timeout fires on the cycle the counter would reach 2^TMO_W-1
    localparam logic [TMO_W-1:0]      TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [FEED_CNT_W-1:0] FEED_LAST = '1;

    state_t                  state, state_n;
    logic [FEED_CNT_W-1:0]   feed_cnt, feed_cnt_n;
    logic                    rd_phase, rd_phase_n;
    logic [TMO_W-1:0]        tmo_cnt, tmo_cnt_n;
    logic                    accept_c;
    bus_cmd_t                cmd, cmd_n;
    logic                    busy_n, done_n, err_n;
    logic [ADDR_W-1:0]       feed_rd_addr_c, feed_wr_addr_c;

    // Addresses for the pair about to be presented
    mat_feed_addr_gen #(
        .A_BASE (A_BASE),
        .B_BASE (B_BASE)
    ) u_feed_addr_gen (
        .cnt       (feed_cnt_n),
        .rd_addr_c (feed_rd_addr_c),
        .wr_addr_c (feed_wr_addr_c)
    );

    // Next-state logic. FEED_RD has two granted phases: address, then the
    // cycle in which the returned read data is captured.
    always_comb begin
        state_n    = state;
        feed_cnt_n = feed_cnt;
        rd_phase_n = rd_phase;
        tmo_cnt_n  = tmo_cnt;
        accept_c   = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_n    = FEED_RD;
                    feed_cnt_n = '0;
                    rd_phase_n = 1'b0;
                end
            end
            FEED_RD: begin
                if (M_grant) begin
                    if (rd_phase) begin
                        rd_phase_n = 1'b0;
                        state_n    = FEED_WR;
                    end else begin
                        rd_phase_n = 1'b1;
                    end
                end
            end
            FEED_WR: begin
                if (M_grant) begin
                    if (feed_cnt == FEED_LAST) begin
                        state_n = MUL_GO;
                    end else begin
                        feed_cnt_n = feed_cnt + FEED_CNT_W'(1);
                        state_n    = FEED_RD;
                    end
                end
            end
            MUL_GO: begin
                if (M_grant) begin
                    state_n   = MUL_WAIT;
                    tmo_cnt_n = '0;
                end
            end
            MUL_WAIT: begin
                if (multi_opdone) begin
                    state_n = INT_EN;
                end else begin
                    tmo_cnt_n = tmo_cnt + TMO_W'(1);
                    if (tmo_cnt == TMO_LAST) state_n = ERR;
                end
            end
            INT_EN: begin
                if (M_grant) state_n = ADD_GO;
            end
            ADD_GO: begin
                if (M_grant) begin
                    state_n   = ADD_WAIT;
                    tmo_cnt_n = '0;
                end
            end
            ADD_WAIT: begin
                if (m_interrupt) begin
                    state_n = RF_RD;
                end else begin
                    tmo_cnt_n = tmo_cnt + TMO_W'(1);
                    if (tmo_cnt == TMO_LAST) state_n = ERR;
                end
            end
            RF_RD: begin
                if (M_grant) state_n = CLR;
            end
            CLR: begin
                if (M_grant) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output decode from the next state so bus outputs are registered and
    // aligned with the state they belong to; address/data hold otherwise.
    always_comb begin
        cmd_n     = cmd;
        cmd_n.req = 1'b0;
        cmd_n.wr  = 1'b0;
        busy_n    = 1'b1;
        done_n    = 1'b0;
        err_n     = err;
        if (accept_c) err_n = 1'b0;
        case (state_n)
            FEED_RD: begin
                cmd_n.req  = 1'b1;
                cmd_n.addr = feed_rd_addr_c;
            end
            FEED_WR: begin
                cmd_n.req  = 1'b1;
                cmd_n.wr   = 1'b1;
                cmd_n.addr = feed_wr_addr_c;
                if (state == FEED_RD) cmd_n.data = M_din;
            end
            MUL_GO:  cmd_n = bus_write(REG_MUL_GO, DATA_W'(1));
            INT_EN:  cmd_n = bus_write(REG_INT_EN, DATA_W'(1));
            ADD_GO:  cmd_n = bus_write(REG_ADD_GO, DATA_W'(1));
            RF_RD: begin
                cmd_n.req  = 1'b1;
                cmd_n.addr = REG_RESULT;
            end
            CLR:     cmd_n = bus_write(REG_CLR, DATA_W'(1));
            IDLE:    busy_n = 1'b0;
            DONE: begin
                busy_n = 1'b0;
                done_n = (state != DONE);
            end
            ERR: begin
                busy_n = 1'b0;
                err_n  = 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            feed_cnt <= '0;
            rd_phase <= 1'b0;
            tmo_cnt  <= '0;
            cmd      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            feed_cnt <= feed_cnt_n;
            rd_phase <= rd_phase_n;
            tmo_cnt  <= tmo_cnt_n;
            cmd      <= cmd_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    assign M_req     = cmd.req;
    assign M_wr      = cmd.wr;
    assign M_address = cmd.addr;
    assign M_dout    = cmd.data;

endmodule

// File: tb/tb_mat_seq_master.sv
// Directed bench for mat_seq_master: memory model, bus transaction log and
// hand-computed expected write sequences.
module tb_mat_seq_master;

    logic        clk;
    logic        reset;
    logic        start;
    logic        M_req;
    logic        M_grant;
    logic        M_wr;
    logic [7:0]  M_address;
    logic [31:0] M_dout;
    logic [31:0] M_din;
    logic        multi_opdone;
    logic        m_interrupt;
    logic        busy;
    logic        done;
    logic        err;

    mat_seq_master #(
        .A_BASE (8'h20),
        .B_BASE (8'h40),
        .TMO_W  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .M_req        (M_req),
        .M_grant      (M_grant),
        .M_wr         (M_wr),
        .M_address    (M_address),
        .M_dout       (M_dout),
        .M_din        (M_din),
        .multi_opdone (multi_opdone),
        .m_interrupt  (m_interrupt),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: read data appears the cycle after a granted read and holds
    logic [31:0] mem [256];
    logic [31:0] rdata;
    assign M_din = rdata;
    always @(posedge clk) begin
        if (M_req && M_grant && !M_wr) rdata <= mem[M_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Granted bus transaction log and done pulse count
    logic [7:0]  wr_a [$];
    logic [31:0] wr_d [$];
    int          wr_t [$];
    logic [7:0]  rd_a [$];
    int          rd_t [$];
    int          done_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (M_req && M_grant) begin
                if (M_wr) begin
                    wr_a.push_back(M_address);
                    wr_d.push_back(M_dout);
                    wr_t.push_back(cyc);
                end else begin
                    rd_a.push_back(M_address);
                    rd_t.push_back(cyc);
                end
            end
            if (done) done_cnt++;
        end
    end

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    logic [7:0]  exp_a [20];
    logic [31:0] exp_d [20];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_wr(input logic [7:0] a, input string tag);
        int n = 0;
        @(negedge clk); #1;
        while (!(M_req && M_grant && M_wr && M_address == a) && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        check_val({tag, " wr seen"}, 32'(n < 2000), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int db);
        int n = 0;
        while (done_cnt == db && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        check_val({tag, " done reached"}, 32'(n < 2000), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_job(input string tag, input int wb, input int rb);
        int n06 = 0;
        check_val({tag, " nwr"}, 32'(wr_a.size() - wb), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (wb + i < wr_a.size()) begin
                check_val($sformatf("%s w%0d addr", tag, i), 32'(wr_a[wb+i]), 32'(exp_a[i]));
                check_val($sformatf("%s w%0d data", tag, i), wr_d[wb+i], exp_d[i]);
            end
        end
        for (int i = rb; i < rd_a.size(); i++) begin
            if (rd_a[i] == 8'h06) n06++;
        end
        check_val({tag, " rd06 count"}, 32'(n06), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " M_req"},     32'(M_req),     32'd0);
        check_val({tag, " M_wr"},      32'(M_wr),      32'd0);
        check_val({tag, " M_address"}, 32'(M_address), 32'd0);
        check_val({tag, " M_dout"},    M_dout,         32'd0);
        check_val({tag, " busy"},      32'(busy),      32'd0);
        check_val({tag, " done"},      32'(done),      32'd0);
        check_val({tag, " err"},       32'(err),       32'd0);
    endtask

    initial begin
        int wb, rb, db, n, rb2, n02;

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h20] = 32'd10; mem[8'h21] = 32'd11; mem[8'h22] = 32'd12; mem[8'h23] = 32'd13;
        mem[8'h40] = 32'd14; mem[8'h41] = 32'd16; mem[8'h42] = 32'd15; mem[8'h43] = 32'd17;

        exp_a = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
                  8'h03, 8'h02, 8'h04, 8'h05};
        exp_d = '{32'd10, 32'd11, 32'd10, 32'd11, 32'd12, 32'd13, 32'd12, 32'd13,
                  32'd14, 32'd16, 32'd15, 32'd17, 32'd14, 32'd16, 32'd15, 32'd17,
                  32'd1, 32'd1, 32'd1, 32'd1};

        reset = 1'b1; start = 1'b0; M_grant = 1'b1;
        multi_opdone = 1'b1; m_interrupt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("idle M_req", 32'(M_req), 32'd0);
        check_val("idle busy",  32'(busy),  32'd0);

        // Nominal job, completion levels already high
        wb = wr_a.size(); rb = rd_a.size(); db = done_cnt;
        pulse_start();
        check_val("nom busy", 32'(busy), 32'd1);
        check_val("nom first rd addr", 32'(M_address), 32'h20);
        wait_done("nom", db);
        check_job("nom", wb, rb);
        check_val("nom done pulses", 32'(done_cnt - db), 32'd1);
        check_val("nom busy after", 32'(busy), 32'd0);
        check_val("nom err", 32'(err), 32'd0);
        if (wr_t.size() >= wb + 19 && rd_a.size() > rb) begin
            check_val("nom mul_wait gap", 32'(wr_t[wb+17] - wr_t[wb+16]), 32'd2);
            check_val("nom add_wait gap", 32'(rd_t[rd_t.size()-1] - wr_t[wb+18]), 32'd2);
            check_val("nom last rd", 32'(rd_a[rd_a.size()-1]), 32'h06);
        end

        // Grant stall on the write of the third feed pair
        wb = wr_a.size(); rb = rd_a.size(); db = done_cnt;
        pulse_start();
        n = 0;
        while (wr_a.size() < wb + 2 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check_val("stall pair2 rd addr", 32'(M_address), 32'h20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        M_grant = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            check_val("stall M_req",  32'(M_req),     32'd1);
            check_val("stall M_wr",   32'(M_wr),      32'd1);
            check_val("stall addr",   32'(M_address), 32'h00);
            check_val("stall data",   M_dout,         32'd10);
            @(posedge clk); #1;
        end
        M_grant = 1'b1;
        wait_done("stall", db);
        check_job("stall", wb, rb);

        // Start while waiting for the multiplier is ignored
        multi_opdone = 1'b0;
        wb = wr_a.size(); rb = rd_a.size(); db = done_cnt;
        pulse_start();
        wait_wr(8'h03, "smw");
        @(posedge clk); #1;
        rb2 = rd_a.size();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("smw M_req", 32'(M_req), 32'd0);
        check_val("smw busy",  32'(busy),  32'd1);
        check_val("smw no new rd", 32'(rd_a.size() - rb2), 32'd0);
        check_val("smw nwr", 32'(wr_a.size() - wb), 32'd17);
        multi_opdone = 1'b1;
        wait_done("smw", db);
        check_job("smw", wb, rb);
        check_val("smw done pulses", 32'(done_cnt - db), 32'd1);

        // Multiplier never finishes -> timeout
        multi_opdone = 1'b0;
        wb = wr_a.size(); rb = rd_a.size(); db = done_cnt;
        pulse_start();
        wait_wr(8'h03, "tmo");
        @(posedge clk); #1;
        check_val("tmo req released", 32'(M_req), 32'd0);
        n = 0;
        while (!err && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("tmo wait cycles", 32'(n), 32'd255);
        check_val("tmo err",  32'(err),   32'd1);
        check_val("tmo M_req", 32'(M_req), 32'd0);
        check_val("tmo busy", 32'(busy),  32'd0);
        repeat (10) @(posedge clk);
        #1;
        n02 = 0;
        for (int i = wb; i < wr_a.size(); i++) begin
            if (wr_a[i] == 8'h02) n02++;
        end
        check_val("tmo no int_en wr", 32'(n02), 32'd0);
        check_val("tmo nwr", 32'(wr_a.size() - wb), 32'd17);
        check_val("tmo err sticky", 32'(err), 32'd1);
        check_val("tmo no done", 32'(done_cnt - db), 32'd0);

        // New start from ERR clears err and runs a full job
        multi_opdone = 1'b1;
        wb = wr_a.size(); rb = rd_a.size(); db = done_cnt;
        pulse_start();
        check_val("rerun err cleared", 32'(err),  32'd0);
        check_val("rerun busy",        32'(busy), 32'd1);
        wait_done("rerun", db);
        check_job("rerun", wb, rb);

        // Reset in the middle of feed pair 6
        wb = wr_a.size();
        pulse_start();
        n = 0;
        while (wr_a.size() < wb + 6 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check_val("rst pair6 rd addr", 32'(M_address), 32'h22);
        reset = 1'b1;
        #1;
        check_all_zero("rst async");
        @(posedge clk); #1;
        check_all_zero("rst edge");
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("rst no retry req",  32'(M_req), 32'd0);
        check_val("rst no retry busy", 32'(busy),  32'd0);
        wb = wr_a.size(); rb = rd_a.size(); db = done_cnt;
        pulse_start();
        check_val("rst restart addr", 32'(M_address), 32'h20);
        check_val("rst restart req",  32'(M_req),     32'd1);
        wait_done("rst restart", db);
        check_job("rst restart", wb, rb);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
